// File: rtl/systolic_feeder.sv
// Operand staging for an NxN systolic array: loads one A/B pair slice by slice,
// then streams it onto the west/north edges with diagonal skew and signals completion.
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_a,
    input  logic [N*DW-1:0] in_b,
    output logic [N*DW-1:0] a_feed,
    output logic [N*DW-1:0] b_feed,
    output logic            feed_act,
    output logic            acc_clr,
    output logic            done
);

    localparam int KW        = (N > 1) ? $clog2(N) : 1;
    localparam int TW        = $clog2(3 * N + 1);
    localparam int TFeedEnd  = 2 * N - 2;
    localparam int TFlushEnd = 3 * N - 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        FEED,
        FLUSH,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [TW-1:0]          t_q, t_d;
    logic [N-1:0][N*DW-1:0] a_buf_q, b_buf_q;
    logic                   ready_q, ready_d;
    logic [N*DW-1:0]        a_feed_q, a_feed_d;
    logic [N*DW-1:0]        b_feed_q, b_feed_d;
    logic                   act_q, act_d;
    logic                   clr_q, clr_d;
    logic                   done_q, done_d;
    logic                   accept;

    assign accept = in_valid & ready_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (N == 1) begin
                        state_d = CLEAR;
                        k_d     = '0;
                    end else begin
                        state_d = LOAD;
                        k_d     = KW'(1);
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    if (k_q == KW'(N - 1)) begin
                        state_d = CLEAR;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_d = FEED;
                t_d     = '0;
            end
            FEED: begin
                t_d = t_q + 1'b1;
                if (t_q == TW'(TFeedEnd)) state_d = FLUSH;
            end
            // Runs one slot past PE[N-1][N-1]'s last product so its accumulator is committed before done.
            FLUSH: begin
                t_d = t_q + 1'b1;
                if (t_q == TW'(TFlushEnd)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                t_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight off a flop.
    always_comb begin
        a_feed_d = '0;
        b_feed_d = '0;
        if (state_d == FEED) begin
            for (int lane = 0; lane < N; lane++) begin
                if (int'(t_d) >= lane && int'(t_d) - lane < N) begin
                    a_feed_d[lane*DW +: DW] = a_buf_q[KW'(int'(t_d) - lane)][lane*DW +: DW];
                    b_feed_d[lane*DW +: DW] = b_buf_q[KW'(int'(t_d) - lane)][lane*DW +: DW];
                end
            end
        end
        ready_d = (state_d == IDLE) || (state_d == LOAD);
        act_d   = (state_d == FEED) || (state_d == FLUSH);
        clr_d   = (state_d == CLEAR);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            t_q      <= '0;
            ready_q  <= 1'b0;
            a_feed_q <= '0;
            b_feed_q <= '0;
            act_q    <= 1'b0;
            clr_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            t_q      <= t_d;
            ready_q  <= ready_d;
            a_feed_q <= a_feed_d;
            b_feed_q <= b_feed_d;
            act_q    <= act_d;
            clr_q    <= clr_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_buf_q <= '0;
            b_buf_q <= '0;
        end else if (accept) begin
            a_buf_q[k_q] <= in_a;
            b_buf_q[k_q] <= in_b;
        end
    end

    assign in_ready = ready_q;
    assign a_feed   = a_feed_q;
    assign b_feed   = b_feed_q;
    assign feed_act = act_q;
    assign acc_clr  = clr_q;
    assign done     = done_q;

endmodule
